// File: rtl/cpu_pkg.sv
// Shared constants for the execute stage: ALU op codes, forward selects and the multiply FSM states.
package cpu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;
  localparam logic [3:0] ALU_MUL   = 4'd11;
  localparam logic [3:0] ALU_MULHU = 4'd12;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef enum logic [1:0] {
    EX_IDLE,
    EX_BUSY,
    EX_DONE
  } ex_state_t;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_MULHU);
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle, XLEN cycles per product.
module mul_iter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic              done,
  output logic [2*XLEN-1:0] product
);

  localparam int CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]  mcand;
  logic [XLEN-1:0]  acc_hi;
  logic [XLEN-1:0]  acc_lo;
  logic [CNT_W-1:0] count;
  logic             running;
  logic [XLEN:0]    partial;

  // The multiplier lives in acc_lo and is consumed LSB first as the accumulator shifts right
  always_comb begin
    partial = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
  end

  assign done    = running && (count == CNT_W'(XLEN - 1));
  assign product = {acc_hi, acc_lo};

  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      running <= 1'b0;
      count   <= '0;
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
    end else if (start) begin
      running <= 1'b1;
      count   <= '0;
      mcand   <= op_a;
      acc_hi  <= '0;
      acc_lo  <= op_b;
    end else if (running) begin
      {acc_hi, acc_lo} <= {partial, acc_lo[XLEN-1:1]};
      count            <= count + 1'b1;
      if (done) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU and EX/MEM register. Define EX_MULDIV_EN to build the
// iterative multiplier (MUL/MULHU stall upstream via ex_busy); otherwise those ops return 0.
module ex_stage
  import cpu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_ex_valid,
  input  logic [XLEN-1:0]       id_ex_rs1_data,
  input  logic [XLEN-1:0]       id_ex_rs2_data,
  input  logic [XLEN-1:0]       id_ex_imm,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic [3:0]            id_ex_alu_op,
  input  logic                  id_ex_alu_src,
  input  logic                  id_ex_reg_write,
  input  logic                  id_ex_mem_read,
  input  logic                  id_ex_mem_write,
  input  logic [1:0]            forward_a,
  input  logic [1:0]            forward_b,
  input  logic [XLEN-1:0]       ex_mem_fwd_data,
  input  logic [XLEN-1:0]       mem_wb_fwd_data,
  input  logic                  flush,
  output logic                  ex_busy,
  output logic                  ex_mem_valid,
  output logic [XLEN-1:0]       ex_mem_alu_result,
  output logic [XLEN-1:0]       ex_mem_store_data,
  output logic [REG_ADDR_W-1:0] ex_mem_rd,
  output logic                  ex_mem_reg_write,
  output logic                  ex_mem_mem_read,
  output logic                  ex_mem_mem_write
);

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] rs2_fwd;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] mul_result;
  logic [4:0]      shamt;
  logic            hold_bubble;
  logic            use_mul;

  // Select 11 is unused by the forwarding unit and falls back to the register file
  always_comb begin
    case (forward_a)
      FWD_EXMEM: op_a = ex_mem_fwd_data;
      FWD_MEMWB: op_a = mem_wb_fwd_data;
      default:   op_a = id_ex_rs1_data;
    endcase
    case (forward_b)
      FWD_EXMEM: rs2_fwd = ex_mem_fwd_data;
      FWD_MEMWB: rs2_fwd = mem_wb_fwd_data;
      default:   rs2_fwd = id_ex_rs2_data;
    endcase
    op_b  = id_ex_alu_src ? id_ex_imm : rs2_fwd;
    shamt = op_b[4:0];
  end

  always_comb begin
    alu_result = '0;
    case (id_ex_alu_op)
      ALU_ADD:   alu_result = op_a + op_b;
      ALU_SUB:   alu_result = op_a - op_b;
      ALU_AND:   alu_result = op_a & op_b;
      ALU_OR:    alu_result = op_a | op_b;
      ALU_XOR:   alu_result = op_a ^ op_b;
      ALU_SLL:   alu_result = op_a << shamt;
      ALU_SRL:   alu_result = op_a >> shamt;
      ALU_SRA:   alu_result = $signed(op_a) >>> shamt;
      ALU_SLT:   alu_result = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SLTU:  alu_result = XLEN'(op_a < op_b);
      ALU_PASSB: alu_result = op_b;
      default:   alu_result = '0;
    endcase
  end

`ifdef EX_MULDIV_EN
  ex_state_t         state;
  ex_state_t         state_next;
  logic              issue;
  logic              mul_done;
  logic              mul_hi_q;
  logic [2*XLEN-1:0] product;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EX_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A multiply stalls upstream from its issue cycle until the last iteration has run
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    ex_busy    = 1'b0;
    case (state)
      EX_IDLE: begin
        if (id_ex_valid && is_mul_op(id_ex_alu_op) && !flush) begin
          issue      = 1'b1;
          ex_busy    = 1'b1;
          state_next = EX_BUSY;
        end
      end
      EX_BUSY: begin
        ex_busy = 1'b1;
        if (mul_done) begin
          state_next = EX_DONE;
        end
      end
      EX_DONE: state_next = EX_IDLE;
      default: state_next = EX_IDLE;
    endcase
    if (flush) begin
      state_next = EX_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_hi_q <= 1'b0;
    end else if (issue) begin
      mul_hi_q <= (id_ex_alu_op == ALU_MULHU);
    end
  end

  mul_iter #(.XLEN(XLEN)) u_mul_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (issue),
    .abort   (flush),
    .op_a    (op_a),
    .op_b    (op_b),
    .done    (mul_done),
    .product (product)
  );

  assign mul_result  = mul_hi_q ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];
  assign hold_bubble = issue || (state == EX_BUSY);
  assign use_mul     = (state == EX_DONE);
`else
  assign ex_busy     = 1'b0;
  assign mul_result  = '0;
  assign hold_bubble = 1'b0;
  assign use_mul     = 1'b0;
`endif

  // Controls are forced low whenever the captured slot is not a live instruction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_mem_valid      <= 1'b0;
      ex_mem_alu_result <= '0;
      ex_mem_store_data <= '0;
      ex_mem_rd         <= '0;
      ex_mem_reg_write  <= 1'b0;
      ex_mem_mem_read   <= 1'b0;
      ex_mem_mem_write  <= 1'b0;
    end else begin
      ex_mem_alu_result <= use_mul ? mul_result : alu_result;
      ex_mem_store_data <= rs2_fwd;
      ex_mem_rd         <= id_ex_rd;
      if (flush || hold_bubble) begin
        ex_mem_valid     <= 1'b0;
        ex_mem_reg_write <= 1'b0;
        ex_mem_mem_read  <= 1'b0;
        ex_mem_mem_write <= 1'b0;
      end else begin
        ex_mem_valid     <= id_ex_valid;
        ex_mem_reg_write <= id_ex_valid & id_ex_reg_write;
        ex_mem_mem_read  <= id_ex_valid & id_ex_mem_read;
        ex_mem_mem_write <= id_ex_valid & id_ex_mem_write;
      end
    end
  end

endmodule
